// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Boot-time loader for the CPU instruction memory. A byte stream carries a
//   16-bit word count, the program words (little-endian), and an 8-bit
//   additive checksum over the data bytes. The loader writes each word into
//   imem and keeps the CPU stalled until an image has loaded with a good
//   checksum. A reload pulse in RUN re-arms it for the next image.
module imem_boot_loader #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          boot_en,
  input  logic          reload,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_hold,
  output logic          load_err,
  output logic [AW:0]   words_loaded
);

  // Depth as a 17-bit value so it compares cleanly against the 16-bit count
  localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

  // S_BOOT is only occupied while reset is held; the first edge after
  // release picks LEN0 or RUN from boot_en.
  typedef enum logic [2:0] {
    S_BOOT,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_RUN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]   r_cnt;
  logic [15:0]   r_word_idx;
  logic [1:0]    r_byte_sel;
  logic [7:0]    r_sum;
  logic [23:0]   r_word;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [31:0]   r_wdata;
  logic          r_load_err;
  logic [AW:0]   r_words_loaded;

  logic          w_accept;
  logic          w_word_done;
  logic          w_last_word;
  logic          w_in_range;
  logic          w_sum_ok;
  logic          w_rearm;
  logic [15:0]   w_cnt_full;
  logic [AW:0]   w_cnt_clamped;

  assign rx_ready = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                    (r_state == S_DATA) || (r_state == S_CSUM);
  assign cpu_hold = (r_state != S_RUN);

  assign w_accept    = rx_valid & rx_ready;
  assign w_cnt_full  = {rx_data, r_cnt[7:0]};
  assign w_word_done = w_accept && (r_state == S_DATA) && (r_byte_sel == 2'd3);
  assign w_last_word = (r_word_idx == (r_cnt - 16'd1));
  // Words past the end of imem are still consumed and summed, just not written
  assign w_in_range  = ({1'b0, r_word_idx} < LP_DEPTH);
  assign w_sum_ok    = (rx_data == r_sum);
  // Both ways back into LEN0 start the next image from clean counters
  assign w_rearm     = ((r_state == S_RUN) && reload) ||
                       ((r_state == S_CSUM) && w_accept && !w_sum_ok);
  assign w_cnt_clamped = ({1'b0, r_cnt} > LP_DEPTH) ? LP_DEPTH[AW:0] : r_cnt[AW:0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_BOOT;
    end else begin
      // NOTE: every clocked register uses <= so all flops update together from
      // the values present before the edge; = here would create order-dependent
      // races between always_ff blocks.
      r_state <= w_next;
    end
  end

  // Next-state decode for the image parser
  always_comb begin
    // NOTE: the default first guarantees w_next is assigned on every path, so
    // no latch is inferred when a case arm leaves it untouched.
    w_next = r_state;
    case (r_state)
      S_BOOT: w_next = boot_en ? S_LEN0 : S_RUN;
      S_LEN0: if (w_accept) w_next = S_LEN1;
      S_LEN1: begin
        if (w_accept) begin
          w_next = (w_cnt_full == 16'd0) ? S_CSUM : S_DATA;
        end
      end
      S_DATA: if (w_word_done && w_last_word) w_next = S_CSUM;
      S_CSUM: begin
        if (w_accept) begin
          w_next = w_sum_ok ? S_RUN : S_LEN0;
        end
      end
      S_RUN:  if (reload) w_next = S_LEN0;
      default: w_next = S_BOOT;
    endcase
  end

  // Byte assembly, checksum accumulation, imem write strobe and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt          <= '0;
      r_word_idx     <= '0;
      r_byte_sel     <= '0;
      r_sum          <= '0;
      r_word         <= '0;
      r_we           <= 1'b0;
      r_waddr        <= '0;
      r_wdata        <= '0;
      r_load_err     <= 1'b0;
      r_words_loaded <= '0;
    end else begin
      r_we <= 1'b0;

      if (w_rearm) begin
        r_byte_sel <= '0;
        r_word_idx <= '0;
        r_sum      <= '0;
      end

      if ((r_state == S_RUN) && reload) begin
        r_load_err <= 1'b0;
      end

      case (r_state)
        S_LEN0: begin
          if (w_accept) r_cnt[7:0] <= rx_data;
        end
        S_LEN1: begin
          if (w_accept) begin
            r_cnt <= w_cnt_full;
            if ({1'b0, w_cnt_full} > LP_DEPTH) r_load_err <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_sum      <= r_sum + rx_data;
            r_byte_sel <= r_byte_sel + 2'd1;
            case (r_byte_sel)
              2'd0: r_word[7:0]   <= rx_data;
              2'd1: r_word[15:8]  <= rx_data;
              2'd2: r_word[23:16] <= rx_data;
              default: begin
                // Fourth byte completes the word; the address saturates at
                // the last written index because out-of-range words never
                // update it.
                if (w_in_range) begin
                  r_we    <= 1'b1;
                  r_waddr <= r_word_idx[AW-1:0];
                  r_wdata <= {rx_data, r_word};
                end
                r_word_idx <= r_word_idx + 16'd1;
              end
            endcase
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            if (w_sum_ok) begin
              r_words_loaded <= w_cnt_clamped;
            end else begin
              r_load_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_we      = r_we;
  assign imem_waddr   = r_waddr;
  assign imem_wdata   = r_wdata;
  assign load_err     = r_load_err;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a full-size instance (DEPTH=512) and a
// tiny instance (DEPTH=4) for the overflow case. Expected imem writes are
// queued as each word is streamed and popped when the write strobe appears.
module tb_imem_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       boot_en;
  logic       reload;
  logic       vld;
  logic       sel_b;
  logic [7:0] rx_data;
  logic       rx_valid_a;
  logic       rx_valid_b;

  assign rx_valid_a = vld & ~sel_b;
  assign rx_valid_b = vld &  sel_b;

  logic        rdy_a, we_a, hold_a, err_a;
  logic [8:0]  waddr_a;
  logic [31:0] wdata_a;
  logic [9:0]  wl_a;

  logic        rdy_b, we_b, hold_b, err_b;
  logic [1:0]  waddr_b;
  logic [31:0] wdata_b;
  logic [2:0]  wl_b;

  imem_boot_loader #(.DEPTH(512), .AW(9)) dut (
    .clk(clk), .reset(reset), .boot_en(boot_en), .reload(reload),
    .rx_valid(rx_valid_a), .rx_data(rx_data), .rx_ready(rdy_a),
    .imem_we(we_a), .imem_waddr(waddr_a), .imem_wdata(wdata_a),
    .cpu_hold(hold_a), .load_err(err_a), .words_loaded(wl_a)
  );

  imem_boot_loader #(.DEPTH(4), .AW(2)) dut4 (
    .clk(clk), .reset(reset), .boot_en(boot_en), .reload(reload),
    .rx_valid(rx_valid_b), .rx_data(rx_data), .rx_ready(rdy_b),
    .imem_we(we_b), .imem_waddr(waddr_b), .imem_wdata(wdata_b),
    .cpu_hold(hold_b), .load_err(err_b), .words_loaded(wl_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [40:0] q_a[$];
  logic [40:0] q_b[$];
  logic [31:0] img[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard for the full-size instance
  always @(negedge clk) begin
    if (!reset && we_a === 1'b1) begin
      n_cmp++;
      assert (q_a.size() > 0) else begin
        n_err++;
        $error("FAIL wr_a_unexpected: observed addr %0h data %0h expected no write", waddr_a, wdata_a);
      end
      if (q_a.size() > 0) check("wr_a", 64'({waddr_a, wdata_a}), 64'(q_a.pop_front()));
    end
  end

  // Scoreboard for the DEPTH=4 instance
  always @(negedge clk) begin
    if (!reset && we_b === 1'b1) begin
      n_cmp++;
      assert (q_b.size() > 0) else begin
        n_err++;
        $error("FAIL wr_b_unexpected: observed addr %0h data %0h expected no write", waddr_b, wdata_b);
      end
      if (q_b.size() > 0) check("wr_b", 64'({7'b0, waddr_b, wdata_b}), 64'(q_b.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one byte until the selected loader takes it (bounded wait)
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    bit   done;
    done    = 1'b0;
    rx_data = b;
    vld     = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      rdy = sel_b ? rdy_b : rdy_a;
      @(posedge clk);
      #1;
      done = rdy;
    end
    vld = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $error("FAIL accept_timeout: observed no accept of byte %0h expected accept within 20 cycles", b);
    end
  endtask

  // Stream cnt words from img, checksum computed here and offset by csum_adj
  task automatic send_image(input int cnt, input logic [7:0] csum_adj, input bit gaps,
                            input bit reload_in_len1, input bit expect_writes);
    logic [7:0]  s;
    logic [31:0] w;
    int          depth;
    s     = 8'h00;
    depth = sel_b ? 4 : 512;
    send_byte(8'(cnt));
    if (reload_in_len1) begin
      reload = 1'b1;
      tick(1);
      reload = 1'b0;
    end
    send_byte(8'(cnt >> 8));
    for (int i = 0; i < cnt; i++) begin
      w = img[i];
      if (expect_writes && i < depth) begin
        if (sel_b) q_b.push_back({9'(i), w});
        else       q_a.push_back({9'(i), w});
      end
      for (int k = 0; k < 4; k++) begin
        s = s + w[8*k +: 8];
        if (gaps) tick(1);
        send_byte(w[8*k +: 8]);
      end
    end
    if (gaps) tick(1);
    check("hold_before_csum", 64'(sel_b ? hold_b : hold_a), 64'(1));
    send_byte(s + csum_adj);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick(1);
    reload = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    boot_en = 1'b1;
    reload  = 1'b0;
    vld     = 1'b0;
    sel_b   = 1'b0;
    rx_data = 8'h00;
    tick(1);

    // Reset values
    check("rst_rx_ready",     64'(rdy_a),   64'(0));
    check("rst_imem_we",      64'(we_a),    64'(0));
    check("rst_imem_waddr",   64'(waddr_a), 64'(0));
    check("rst_imem_wdata",   64'(wdata_a), 64'(0));
    check("rst_cpu_hold",     64'(hold_a),  64'(1));
    check("rst_load_err",     64'(err_a),   64'(0));
    check("rst_words_loaded", 64'(wl_a),    64'(0));
    reset = 1'b0;
    tick(1);
    check("boot_rx_ready", 64'(rdy_a),  64'(1));
    check("boot_cpu_hold", 64'(hold_a), 64'(1));

    // Two-word image, good checksum
    img = {32'hE3A0000A, 32'hE3A01005};
    send_image(2, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t1_cpu_hold",     64'(hold_a), 64'(0));
    check("t1_rx_ready",     64'(rdy_a),  64'(0));
    check("t1_load_err",     64'(err_a),  64'(0));
    check("t1_words_loaded", 64'(wl_a),   64'(2));
    check("t1_q_empty",      64'(q_a.size()), 64'(0));

    // Bad checksum, then a good resend: error stays until reload
    pulse_reload();
    check("t2_hold_after_reload", 64'(hold_a), 64'(1));
    check("t2_ready_after_reload", 64'(rdy_a), 64'(1));
    send_image(2, 8'h01, 1'b0, 1'b0, 1'b1);
    check("t2_bad_load_err",     64'(err_a),  64'(1));
    check("t2_bad_cpu_hold",     64'(hold_a), 64'(1));
    check("t2_bad_rx_ready",     64'(rdy_a),  64'(1));
    check("t2_bad_words_loaded", 64'(wl_a),   64'(2));
    send_image(2, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t2_resend_cpu_hold", 64'(hold_a), 64'(0));
    check("t2_resend_load_err", 64'(err_a),  64'(1));
    pulse_reload();
    check("t2_reload_clears_err", 64'(err_a), 64'(0));

    // Empty image
    send_image(0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t4_cpu_hold",     64'(hold_a), 64'(0));
    check("t4_words_loaded", 64'(wl_a),   64'(0));
    check("t4_load_err",     64'(err_a),  64'(0));

    // Gapped stream with a reload pulse while in LEN1
    pulse_reload();
    send_image(2, 8'h00, 1'b1, 1'b1, 1'b1);
    check("t5_cpu_hold",     64'(hold_a), 64'(0));
    check("t5_words_loaded", 64'(wl_a),   64'(2));
    check("t5_load_err",     64'(err_a),  64'(0));
    check("t5_q_empty",      64'(q_a.size()), 64'(0));

    // boot_en=0: straight to RUN, stream ignored
    boot_en = 1'b0;
    reset   = 1'b1;
    tick(1);
    check("t3_rst_cpu_hold",     64'(hold_a), 64'(1));
    check("t3_rst_words_loaded", 64'(wl_a),   64'(0));
    reset = 1'b0;
    tick(1);
    check("t3_cpu_hold", 64'(hold_a), 64'(0));
    check("t3_rx_ready", 64'(rdy_a),  64'(0));
    rx_data = 8'hAA;
    vld     = 1'b1;
    tick(4);
    vld = 1'b0;
    check("t3_idle_cpu_hold", 64'(hold_a), 64'(0));
    check("t3_idle_rx_ready", 64'(rdy_a),  64'(0));

    // DEPTH=4 instance, five-word image overflows
    boot_en = 1'b1;
    sel_b   = 1'b1;
    reset   = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    img.delete();
    for (int i = 0; i < 5; i++) img.push_back(32'hA0302010 + 32'h01010101 * 32'(i));
    send_image(5, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t6_load_err",     64'(err_b),   64'(1));
    check("t6_cpu_hold",     64'(hold_b),  64'(0));
    check("t6_words_loaded", 64'(wl_b),    64'(4));
    check("t6_waddr_sat",    64'(waddr_b), 64'(3));
    check("t6_q_empty",      64'(q_b.size()), 64'(0));

    // Reset mid-DATA, with a write strobe in flight
    pulse_reload();
    check("t6_reload_clears_err", 64'(err_b), 64'(0));
    send_byte(8'h05);
    send_byte(8'h00);
    check("t6_len1_overflow_err", 64'(err_b), 64'(1));
    send_byte(8'h44);
    send_byte(8'h33);
    send_byte(8'h22);
    send_byte(8'h11);
    check("t6_we_pulse", 64'(we_b),    64'(1));
    check("t6_wdata",    64'(wdata_b), 64'(32'h11223344));
    #1;
    reset = 1'b1;
    #1;
    check("t6_async_rx_ready",     64'(rdy_b),   64'(0));
    check("t6_async_imem_we",      64'(we_b),    64'(0));
    check("t6_async_imem_wdata",   64'(wdata_b), 64'(0));
    check("t6_async_cpu_hold",     64'(hold_b),  64'(1));
    check("t6_async_load_err",     64'(err_b),   64'(0));
    check("t6_async_words_loaded", 64'(wl_b),    64'(0));
    tick(1);
    reset = 1'b0;
    tick(2);
    check("end_q_a_empty", 64'(q_a.size()), 64'(0));
    check("end_q_b_empty", 64'(q_b.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
